// File: rtl/frame_fifo_read_arbiter.sv
// frame_fifo_read_arbiter
// Frame-atomic, round-robin read scheduler that drains NUM_PORTS FWFT frame
// FIFOs (9-bit words: [7:0] data, [8] end-of-frame) onto one byte stream.
// A granted port keeps the grant until its end-of-frame word is read, so
// frames from different ports are never interleaved.
//
// Optional feature macro: FRAME_ARB_LEN_LIMIT_EN
//   When defined, frames longer than MAX_FRAME_LEN are cut at MAX_FRAME_LEN
//   bytes (last byte flagged OUT_LAST), o_len_err pulses, and the rest of the
//   frame is read and discarded in the DRAIN state.
//
// Output handshake: a word moves downstream on every rising i_clk edge where
// o_out_valid and i_out_ready are both 1; while o_out_valid=1 and
// i_out_ready=0 the data/last outputs hold their value.
module frame_fifo_read_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NUM_PORTS-1:0]   i_fifo_empty,
  input  logic [9*NUM_PORTS-1:0] i_fifo_q,
  output logic [NUM_PORTS-1:0]   o_fifo_re,
  output logic [7:0]             o_out_data,
  output logic                   o_out_last,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [NUM_PORTS-1:0]   o_grant,
  output logic                   o_len_err,
  output logic [1:0]             o_dbg_state
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  // Reject out-of-range configurations at elaboration time.
  if (NUM_PORTS < 2 || NUM_PORTS > 8 || MAX_FRAME_LEN < 2 || MAX_FRAME_LEN > 2047) begin : g_param_check
    $error("frame_fifo_read_arbiter: parameter out of range");
  end

`ifdef FRAME_ARB_LEN_LIMIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1} state_t;
`endif

  state_t               r_state;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [NUM_PORTS-1:0] r_grant;
  logic [PTR_W-1:0]     r_gidx;
  logic [7:0]           r_out_data;
  logic                 r_out_last;
  logic                 r_out_valid;
`ifdef FRAME_ARB_LEN_LIMIT_EN
  logic [10:0]          r_cnt;
  logic                 r_len_err;
  logic                 w_drain_rd;
`endif

  logic [8:0]           w_head;
  logic                 w_g_empty;
  logic                 w_out_free;
  logic                 w_xfer_rd;
  logic                 w_rd;
  logic                 w_trunc;
  logic [PTR_W-1:0]     w_next_ptr;
  logic [PTR_W:0]       w_cand;
  logic                 w_sel_valid;
  logic [PTR_W-1:0]     w_sel_idx;
  logic [NUM_PORTS-1:0] w_sel_onehot;

  // Head word of the granted FIFO (grant is one-hot, so OR-ing is a mux).
  always_comb begin
    w_head = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[i]) w_head = w_head | i_fifo_q[9*i +: 9];
    end
  end

  assign w_g_empty  = |(r_grant & i_fifo_empty);
  assign w_out_free = !r_out_valid || i_out_ready;
  assign w_xfer_rd  = (r_state == S_XFER) && !w_g_empty && w_out_free;

`ifdef FRAME_ARB_LEN_LIMIT_EN
  // DRAIN discards words, so it reads regardless of downstream readiness.
  assign w_drain_rd = (r_state == S_DRAIN) && !w_g_empty;
  assign w_rd       = w_xfer_rd || w_drain_rd;
  // The MAX_FRAME_LEN-th byte without EOF becomes a forced end of frame.
  assign w_trunc    = (r_cnt == 11'(MAX_FRAME_LEN - 1)) && !w_head[8];
`else
  assign w_rd       = w_xfer_rd;
  assign w_trunc    = 1'b0;
`endif

  assign o_fifo_re  = w_rd ? r_grant : '0;

  // Round-robin pointer moves to the port after the one just finished.
  assign w_next_ptr = (r_gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : r_gidx + PTR_W'(1);

  // First non-empty port searching upward from r_rr_ptr with wrap-around.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_cand >= (PTR_W+1)'(NUM_PORTS)) w_cand = w_cand - (PTR_W+1)'(NUM_PORTS);
      if (!w_sel_valid && !i_fifo_empty[w_cand[PTR_W-1:0]]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = w_cand[PTR_W-1:0];
      end
    end
  end

  assign w_sel_onehot = NUM_PORTS'(1) << w_sel_idx;

  // Arbitration FSM, output register and frame byte counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef FRAME_ARB_LEN_LIMIT_EN
      r_cnt       <= '0;
      r_len_err   <= 1'b0;
`endif
    end else begin
`ifdef FRAME_ARB_LEN_LIMIT_EN
      r_len_err <= 1'b0;
`endif
      if (w_xfer_rd) begin
        r_out_data  <= w_head[7:0];
        r_out_last  <= w_head[8] | w_trunc;
        r_out_valid <= 1'b1;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_grant <= w_sel_onehot;
            r_gidx  <= w_sel_idx;
            r_state <= S_XFER;
`ifdef FRAME_ARB_LEN_LIMIT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_XFER: begin
          if (w_xfer_rd) begin
`ifdef FRAME_ARB_LEN_LIMIT_EN
            if (r_cnt != 11'(MAX_FRAME_LEN)) r_cnt <= r_cnt + 11'd1;
`endif
            if (w_head[8]) begin
              r_state  <= S_IDLE;
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
            end
`ifdef FRAME_ARB_LEN_LIMIT_EN
            else if (w_trunc) begin
              r_state   <= S_DRAIN;
              r_len_err <= 1'b1;
            end
`endif
          end
        end
`ifdef FRAME_ARB_LEN_LIMIT_EN
        S_DRAIN: begin
          if (w_drain_rd && w_head[8]) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_out_valid = r_out_valid;
  assign o_grant     = r_grant;
  assign o_dbg_state = r_state;
`ifdef FRAME_ARB_LEN_LIMIT_EN
  assign o_len_err   = r_len_err;
`else
  assign o_len_err   = 1'b0;
`endif

endmodule

// File: tb/tb_frame_fifo_read_arbiter.sv
// Bench for frame_fifo_read_arbiter: FWFT FIFOs modelled as queues, expected
// byte stream and grant order produced by a frame-level round-robin model.
module tb_frame_fifo_read_arbiter;

  localparam int N = 4;
`ifdef FRAME_ARB_LEN_LIMIT_EN
  localparam int MAXL  = 4;
  localparam bit LIMIT = 1'b1;
`else
  localparam int MAXL  = 1518;
  localparam bit LIMIT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   i_fifo_empty;
  logic [9*N-1:0] i_fifo_q;
  logic [N-1:0]   o_fifo_re;
  logic [7:0]     o_out_data;
  logic           o_out_last;
  logic           o_out_valid;
  logic           i_out_ready;
  logic [N-1:0]   o_grant;
  logic           o_len_err;
  logic [1:0]     o_dbg_state;

  frame_fifo_read_arbiter #(.NUM_PORTS(N), .MAX_FRAME_LEN(MAXL)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_fifo_empty(i_fifo_empty), .i_fifo_q(i_fifo_q),
    .o_fifo_re(o_fifo_re), .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_grant(o_grant),
    .o_len_err(o_len_err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- environment / model state ----------------
  logic [8:0] fq [N][$];     // physical FIFO contents seen by the DUT
  logic [8:0] mq [N][$];     // complete frames handed to the model
  logic [8:0] held_q[$];     // bytes withheld from a FIFO to force a stall
  logic [8:0] exp_q[$];      // scoreboard: expected {last,data}
  int         exp_grant[$];  // expected grant order
  int         m_ptr;
  int         exp_len_err, got_len_err;
  int         n_tests, n_fail;
  int         ready_mode;    // 0 random, 1 always ready, 2 never ready
  bit         stall_en;
  logic [N-1:0] stall;
  int         cyc, first_hs, last_hs;
  logic [N-1:0] s_grant, s_re, s_prev_grant;
  bit         s_prev_eof_rd, s_prev_valid, s_prev_ready;
  logic [8:0] s_prev_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_fifos();
    for (int i = 0; i < N; i++) begin
      i_fifo_empty[i]   = (fq[i].size() == 0) || (stall[i] && o_grant[i]);
      i_fifo_q[9*i +: 9] = (fq[i].size() != 0) ? fq[i][0] : 9'h000;
    end
  endtask

  task automatic add_frame(input int port, input int len, input int base);
    logic [8:0] w;
    for (int b = 0; b < len; b++) begin
      w[7:0] = (base >= 0) ? 8'(base + b) : 8'($urandom_range(0, 255));
      w[8]   = (b == len - 1);
      fq[port].push_back(w);
      mq[port].push_back(w);
    end
  endtask

  // Frame-level model: serve whole frames round-robin from m_ptr.
  task automatic plan();
    int sel, n;
    bit found, dropping;
    logic [8:0] w;
    forever begin
      found = 1'b0;
      sel = 0;
      for (int k = 0; k < N; k++)
        if (!found && mq[(m_ptr + k) % N].size() > 0) begin
          found = 1'b1;
          sel = (m_ptr + k) % N;
        end
      if (!found) break;
      exp_grant.push_back(sel);
      n = 0;
      dropping = 1'b0;
      do begin
        w = mq[sel].pop_front();
        n++;
        if (!dropping) begin
          if (LIMIT && n == MAXL && !w[8]) begin
            exp_q.push_back({1'b1, w[7:0]});
            exp_len_err++;
            dropping = 1'b1;
          end else begin
            exp_q.push_back(w);
          end
        end
      end while (!w[8]);
      m_ptr = (sel + 1) % N;
    end
  endtask

  function automatic bit fifos_busy();
    for (int i = 0; i < N; i++) if (fq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive after the rising edge, sample at the falling edge,
  // pop FIFOs just after the next rising edge.
  task automatic step();
    int p;
    bit eof_rd;
    case (ready_mode)
      1: i_out_ready = 1'b1;
      2: i_out_ready = 1'b0;
      default: i_out_ready = ($urandom_range(0, 3) != 0);
    endcase
    for (int i = 0; i < N; i++) stall[i] = stall_en && ($urandom_range(0, 7) == 0);
    drive_fifos();
    @(negedge clk);
    cyc++;
    s_grant = o_grant;
    s_re    = o_fifo_re;
    chk("re_in_grant", 32'(o_fifo_re & ~o_grant), 32'h0);
    chk("re_when_empty", 32'(o_fifo_re & i_fifo_empty), 32'h0);
    if (s_prev_eof_rd) begin
      chk("gap_re", 32'(o_fifo_re), 32'h0);
      chk("gap_grant", 32'(o_grant), 32'h0);
    end
    if (o_grant != 0 && s_prev_grant == 0) begin
      chk("grant_avail", 32'(exp_grant.size() > 0), 32'h1);
      if (exp_grant.size() > 0) begin
        p = exp_grant.pop_front();
        chk("grant_order", 32'(o_grant), 32'(1 << p));
      end
    end
    if (s_prev_valid && !s_prev_ready) begin
      chk("hold_valid", 32'(o_out_valid), 32'h1);
      chk("hold_word", 32'({o_out_last, o_out_data}), 32'(s_prev_word));
    end
    if (o_len_err) got_len_err++;
    if (o_out_valid && i_out_ready) begin
      chk("out_avail", 32'(exp_q.size() > 0), 32'h1);
      if (exp_q.size() > 0) chk("out_word", 32'({o_out_last, o_out_data}), 32'(exp_q.pop_front()));
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    eof_rd = 1'b0;
    for (int i = 0; i < N; i++)
      if (o_fifo_re[i] && fq[i].size() != 0 && fq[i][0][8]) eof_rd = 1'b1;
    s_prev_eof_rd = eof_rd;
    s_prev_grant  = o_grant;
    s_prev_valid  = o_out_valid;
    s_prev_ready  = i_out_ready;
    s_prev_word   = {o_out_last, o_out_data};
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (s_re[i] && fq[i].size() != 0) void'(fq[i].pop_front());
  endtask

  task automatic run_until_drained();
    int n = 0;
    while ((exp_q.size() != 0 || o_grant != 0 || o_out_valid || fifos_busy()) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < 3000), 32'h1);
    repeat (2) step();
  endtask

  task automatic end_round(input string tag);
    chk({tag, "_grants_left"}, 32'(exp_grant.size()), 32'h0);
    chk({tag, "_words_left"}, 32'(exp_q.size()), 32'h0);
    chk({tag, "_len_err_cnt"}, 32'(got_len_err), 32'(exp_len_err));
    got_len_err = 0;
    exp_len_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(o_grant), 32'h0);
    chk({tag, "_re"}, 32'(o_fifo_re), 32'h0);
    chk({tag, "_valid"}, 32'(o_out_valid), 32'h0);
    chk({tag, "_data"}, 32'(o_out_data), 32'h0);
    chk({tag, "_last"}, 32'(o_out_last), 32'h0);
    chk({tag, "_len_err"}, 32'(o_len_err), 32'h0);
  endtask

  task automatic clear_after_reset();
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    exp_grant.delete();
    m_ptr = 0;
    got_len_err = 0;
    exp_len_err = 0;
    s_prev_eof_rd = 1'b0;
    s_prev_valid  = 1'b0;
    s_prev_ready  = 1'b0;
    s_prev_grant  = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0;
    i_out_ready = 1'b0;
    stall = '0;
    stall_en = 1'b0;
    ready_mode = 1;
    clear_after_reset();

    // Reset with every FIFO non-empty; two 1-byte frames per port.
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) add_frame(p, 1, 8'h80 + 16 * r + p);
    plan();
    drive_fifos();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    step();
    chk("first_grant", 32'(s_grant), 32'h1);
    chk("first_re", 32'(s_re), 32'h1);
    run_until_drained();
    end_round("rr");

    // Two 3-byte frames on ports 0 and 2: back to back with one idle cycle.
    add_frame(0, 3, 8'h11);
    add_frame(2, 3, 8'h21);
    plan();
    first_hs = -1;
    run_until_drained();
    chk("two_frame_span", 32'(last_hs - first_hs), 32'd6);
    end_round("two");

    // Backpressure: downstream stalls for 5 cycles mid-frame.
    add_frame(0, 4, 8'h31);
    plan();
    repeat (3) step();
    ready_mode = 2;
    repeat (5) begin
      step();
      chk("bp_no_re", 32'(s_re), 32'h0);
    end
    ready_mode = 1;
    run_until_drained();
    end_round("bp");

    // Port 1 runs dry after 2 of 4 bytes while port 3 waits with a frame.
    for (int b = 0; b < 4; b++) begin
      mq[1].push_back({b == 3, 8'(8'h41 + b)});
      if (b < 2) fq[1].push_back({1'b0, 8'(8'h41 + b)});
      else held_q.push_back({b == 3, 8'(8'h41 + b)});
    end
    add_frame(3, 3, 8'h61);
    plan();
    step();
    for (int s = 0; s < 13; s++) begin
      step();
      chk("stall_grant", 32'(s_grant), 32'h2);
      chk("stall_no_p3", 32'(s_re[3]), 32'h0);
    end
    while (held_q.size() != 0) fq[1].push_back(held_q.pop_front());
    run_until_drained();
    end_round("dry");

    // Randomized rounds: random frames, backpressure and mid-frame stalls.
    ready_mode = 0;
    stall_en = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int p = 0; p < N; p++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 6), -1);
      end
      plan();
      run_until_drained();
      end_round("rand");
    end

    // Asynchronous reset in the middle of a frame.
    ready_mode = 1;
    stall_en = 1'b0;
    add_frame(2, 6, 8'hA0);
    plan();
    repeat (3) step();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    clear_after_reset();
    drive_fifos();
    @(negedge clk);
    reset_n = 1'b1;

    // Recovery after reset: pointer restarts at port 0.
    ready_mode = 0;
    stall_en = 1'b1;
    for (int p = 0; p < N; p++) add_frame(p, $urandom_range(1, 6), -1);
    plan();
    run_until_drained();
    end_round("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
